// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and response channels of the ALU sequencer.
// master = command producer / response consumer, slave = the sequencer.
interface alu_op_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_opcode;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_lo;
  logic [31:0]      rsp_hi;
  logic [2:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_tag
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/collect stage for the registered 32-bit ALU.
// Commands are issued only when a response FIFO slot is reserved for them
// (credits = FIFO occupancy + ops in flight). Results are captured two edges
// after issue and returned in order through a DEPTH-entry FIFO.
// Optional feature: define ALU_SEQ_STATS_EN to add the stat_ops/stat_errs
// saturating counters (counted at FIFO write).
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [1:0]        alu_opcode,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_lo,
  input  logic [31:0]       alu_hi,
  input  logic              alu_carry,
  input  logic              alu_borrow,
  input  logic              alu_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [15:0]       stat_errs
`endif
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = 32 + 32 + 3 + TAG_W;
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  logic               ready_en;
  logic               s1_v;
  logic               s2_v;
  logic [TAG_W-1:0]   s1_tag;
  logic [TAG_W-1:0]   s2_tag;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   count;
  logic [PTR_W:0]     reserved;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] entry;
  logic               accept;
  logic               push;
  logic               pop;
  logic               empty;

  // Pointers carry one extra wrap bit, so their difference is the occupancy
  // and equality means empty.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign reserved = {1'b0, count} + {{PTR_W{1'b0}}, s1_v} + {{PTR_W{1'b0}}, s2_v};

  // cmd_ready depends only on registered state; ready_en holds it low during
  // reset and releases it at the first edge afterwards.
  assign bus.cmd_ready = ready_en && (reserved < DEPTH_L);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign push          = s2_v;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // ALU result bits are undefined on error, so they are stored as zero.
  assign entry = {alu_err ? 32'h0 : alu_lo, alu_err ? 32'h0 : alu_hi,
                  alu_err, alu_borrow, alu_carry, s2_tag};
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  assign bus.rsp_valid = !empty;
  assign {bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, bus.rsp_tag} = empty ? '0 : head;

  // Enable command acceptance one edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Register the accepted command onto the ALU inputs; hold them when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 2'b00;
      alu_a      <= 32'h0;
      alu_b      <= 32'h0;
    end else if (accept) begin
      alu_opcode <= bus.cmd_opcode;
      alu_a      <= bus.cmd_a;
      alu_b      <= bus.cmd_b;
    end
  end

  // Two-stage {valid, tag} shift tracking ops in the ALU (s1) and at capture (s2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_tag <= '0;
      s2_tag <= '0;
    end else begin
      s1_v   <= accept;
      s1_tag <= bus.cmd_tag;
      s2_v   <= s1_v;
      s2_tag <= s1_tag;
    end
  end

  // FIFO pointers; the credit scheme guarantees a push never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are masked off while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= entry;
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating counts of responses written and of those flagged as errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (push) begin
      if (stat_ops != '1)             stat_ops  <= stat_ops + 1'b1;
      if (alu_err && stat_errs != '1) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer
// against a queue-based reference model of the expected responses.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      lo;
    logic [31:0]      hi;
    logic [2:0]       flags;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.TAG_W(TAG_W)) bus ();

  logic [1:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_lo = '0;
  logic [31:0] alu_hi = '0;
  logic        alu_carry = 1'b0;
  logic        alu_borrow = 1'b0;
  logic        alu_err = 1'b0;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  int   n_checks = 0;
  int   n_pass = 0;
  rsp_t exp_q[$];

  alu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_lo(alu_lo), .alu_hi(alu_hi), .alu_carry(alu_carry),
    .alu_borrow(alu_borrow), .alu_err(alu_err)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  // Registered ALU device; result bits are garbage when dividing by zero.
  always @(posedge clk) begin
    alu_carry  <= 1'b0;
    alu_borrow <= 1'b0;
    alu_err    <= 1'b0;
    alu_hi     <= 32'h0;
    case (alu_opcode)
      2'b00: {alu_carry, alu_lo} <= {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin alu_lo <= alu_a - alu_b; alu_borrow <= (alu_a < alu_b); end
      2'b10: {alu_hi, alu_lo} <= {32'h0, alu_a} * {32'h0, alu_b};
      default:
        if (alu_b == 32'h0) begin
          alu_err <= 1'b1; alu_lo <= 32'hDEAD_BEEF; alu_hi <= 32'hBAAD_F00D;
        end else begin
          alu_lo <= alu_a / alu_b; alu_hi <= alu_a % alu_b;
        end
    endcase
  end

  // Expected response from the arithmetic meaning of each opcode.
  function automatic rsp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag);
    rsp_t r;
    longint unsigned ua, ub, p;
    ua = a; ub = b; r = '0; r.tag = tag;
    case (op)
      2'd0: begin r.lo = a + b; r.flags[0] = (ua + ub) > 64'hFFFF_FFFF; end
      2'd1: begin r.lo = a - b; r.flags[1] = ua < ub; end
      2'd2: begin p = ua * ub; r.lo = p[31:0]; r.hi = p[63:32]; end
      default:
        if (b == 32'h0) r.flags[2] = 1'b1;
        else begin r.lo = a / b; r.hi = a % b; end
    endcase
    return r;
  endfunction

  task automatic rand_cmd(output logic [1:0] op, output logic [31:0] a,
                          output logic [31:0] b, output logic [TAG_W-1:0] tag);
    op  = 2'($urandom_range(0, 3));
    a   = $urandom;
    b   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    tag = TAG_W'($urandom_range(0, 15));
  endtask

  // Drive one cycle at the falling edge, sample outputs, then wait for the rising edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag, input logic rr,
                      output logic rdy, output logic vld, output rsp_t head);
    @(negedge clk);
    bus.cmd_valid = v; bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_tag = tag; bus.rsp_ready = rr;
    #1;
    rdy = bus.cmd_ready;
    vld = bus.rsp_valid;
    head = {bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, bus.rsp_tag};
    @(posedge clk);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_opcode = 0; bus.cmd_a = 0; bus.cmd_b = 0;
    bus.cmd_tag = 0; bus.rsp_ready = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b0) $display("[TB] FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready);
    else n_pass++;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
    else n_pass++;
    n_checks++;
    if ({alu_opcode, alu_a, alu_b} !== 66'h0)
      $display("[TB] FAIL reset_alu_regs: got %h want 0", {alu_opcode, alu_a, alu_b});
    else n_pass++;
    n_checks++;
    if ({bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, bus.rsp_tag} !== '0)
      $display("[TB] FAIL reset_rsp_bus: got %h want 0", {bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, bus.rsp_tag});
    else n_pass++;
    rst_n = 1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL release_cmd_ready: got %b want 1", bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic rdy, vld; rsp_t h; int lat;
    step(1, 2'b00, 32'hFFFF_FFFF, 32'h1, 4'd3, 1, rdy, vld, h);
    #1;
    n_checks++;
    if (rdy !== 1'b1) $display("[TB] FAIL lat_accept: got %b want 1", rdy);
    else n_pass++;
    n_checks++;
    if ({alu_opcode, alu_a, alu_b} !== {2'b00, 32'hFFFF_FFFF, 32'h1})
      $display("[TB] FAIL lat_alu_inputs: got %h want %h", {alu_opcode, alu_a, alu_b}, {2'b00, 32'hFFFF_FFFF, 32'h1});
    else n_pass++;
    lat = 0; vld = 0;
    while (!vld && lat < 10) begin
      step(0, 2'b00, 32'h0, 32'h0, 4'd0, 1, rdy, vld, h);
      lat++;
    end
    n_checks++;
    if (lat !== 3) $display("[TB] FAIL lat_cycles: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (h !== {32'h0, 32'h0, 3'b001, 4'd3}) $display("[TB] FAIL lat_add_rsp: got %h want %h", h, {32'h0, 32'h0, 3'b001, 4'd3});
    else n_pass++;
  endtask

  task automatic test_div_mul();
    logic rdy, vld; rsp_t h; rsp_t got[$];
    step(1, 2'b11, 32'd7, 32'd0, 4'd5, 1, rdy, vld, h);
    step(1, 2'b10, 32'h0001_0000, 32'h0001_0000, 4'd6, 1, rdy, vld, h);
    for (int c = 0; c < 12 && got.size() < 2; c++) begin
      step(0, 2'b00, 32'h0, 32'h0, 4'd0, 1, rdy, vld, h);
      if (vld) got.push_back(h);
    end
    n_checks++;
    if (got.size() !== 2) $display("[TB] FAIL divmul_count: got %0d want 2", got.size());
    else n_pass++;
    if (got.size() == 2) begin
      n_checks++;
      if (got[0] !== {32'h0, 32'h0, 3'b100, 4'd5}) $display("[TB] FAIL div_by_zero_rsp: got %h want %h", got[0], {32'h0, 32'h0, 3'b100, 4'd5});
      else n_pass++;
      n_checks++;
      if (got[1] !== {32'h0, 32'h1, 3'b000, 4'd6}) $display("[TB] FAIL mul_rsp: got %h want %h", got[1], {32'h0, 32'h1, 3'b000, 4'd6});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, vld; rsp_t h, e; logic [1:0] op; logic [31:0] a, b; logic [TAG_W-1:0] tg;
    int nacc = 0, npop = 0, first = -1, last = -1;
    op = 0; a = 0; b = 0; tg = 0;
    for (int c = 0; c < 30 && (nacc < 8 || exp_q.size() > 0); c++) begin
      if (nacc < 8) rand_cmd(op, a, b, tg);
      step(nacc < 8, op, a, b, tg, 1, rdy, vld, h);
      if (nacc < 8) begin
        n_checks++;
        if (rdy !== 1'b1) $display("[TB] FAIL b2b_cmd_ready: got %b want 1 (cmd %0d)", rdy, nacc);
        else n_pass++;
        if (rdy) begin exp_q.push_back(model(op, a, b, tg)); nacc++; end
      end
      if (vld) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if (h !== e) $display("[TB] FAIL b2b_rsp: got %h want %h", h, e);
        else n_pass++;
        if (first < 0) first = c;
        last = c; npop++;
      end
    end
    n_checks++;
    if (npop !== 8 || last - first !== 7)
      $display("[TB] FAIL b2b_rate: got %0d rsps over %0d cycles want 8 over 8", npop, last - first + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic rdy, vld, seen, stable; rsp_t h, e, first_head; logic [1:0] op; logic [31:0] a, b; logic [TAG_W-1:0] tg;
    int nacc = 0, nmore = 0;
    seen = 0; stable = 1; first_head = '0; rdy = 0;
    for (int c = 0; c < 10; c++) begin
      rand_cmd(op, a, b, tg);
      step(1, op, a, b, tg, 0, rdy, vld, h);
      if (rdy) begin exp_q.push_back(model(op, a, b, tg)); nacc++; end
      if (vld) begin
        if (!seen) begin first_head = h; seen = 1; end
        else if (h !== first_head) stable = 0;
      end
    end
    n_checks++;
    if (nacc !== DEPTH) $display("[TB] FAIL bp_accepted: got %0d want %0d", nacc, DEPTH);
    else n_pass++;
    n_checks++;
    if (rdy !== 1'b0) $display("[TB] FAIL bp_cmd_ready_full: got %b want 0", rdy);
    else n_pass++;
    n_checks++;
    if (!(seen && stable)) $display("[TB] FAIL bp_head_stable: got seen=%b stable=%b want 1 1", seen, stable);
    else n_pass++;
    step(0, 2'b00, 32'h0, 32'h0, 4'd0, 1, rdy, vld, h);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if (!vld || h !== e) $display("[TB] FAIL bp_single_pop: got vld=%b %h want vld=1 %h", vld, h, e);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      rand_cmd(op, a, b, tg);
      step(1, op, a, b, tg, 0, rdy, vld, h);
      if (rdy) begin exp_q.push_back(model(op, a, b, tg)); nmore++; end
    end
    n_checks++;
    if (nmore !== 1) $display("[TB] FAIL bp_one_more: got %0d want 1", nmore);
    else n_pass++;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step(0, 2'b00, 32'h0, 32'h0, 4'd0, 1, rdy, vld, h);
      if (vld) begin
        e = exp_q.pop_front();
        n_checks++;
        if (h !== e) $display("[TB] FAIL bp_drain_rsp: got %h want %h", h, e);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) $display("[TB] FAIL bp_drain_done: got %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic rdy, vld, v, rr; rsp_t h, e; logic [1:0] op; logic [31:0] a, b; logic [TAG_W-1:0] tg;
    int outstanding = 0;
    for (int c = 0; c < 400; c++) begin
      rand_cmd(op, a, b, tg);
      v  = (c < 300) && ($urandom_range(0, 3) != 0);
      rr = (c >= 300) || ($urandom_range(0, 2) != 0);
      step(v, op, a, b, tg, rr, rdy, vld, h);
      n_checks++;
      if (rdy !== (outstanding < DEPTH)) $display("[TB] FAIL rand_credit: got %b want %b", rdy, outstanding < DEPTH);
      else n_pass++;
      if (v && rdy) begin exp_q.push_back(model(op, a, b, tg)); outstanding++; end
      if (vld && rr) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if (h !== e) $display("[TB] FAIL rand_rsp: got %h want %h", h, e);
        else n_pass++;
        outstanding--;
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) $display("[TB] FAIL rand_drain_done: got %0d left want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic rdy, vld; rsp_t h; logic [1:0] op; logic [31:0] a, b; logic [TAG_W-1:0] tg;
    int nacc = 0, nvld = 0;
    for (int c = 0; c < 4; c++) begin
      rand_cmd(op, a, b, tg);
      step(1, op, a, b, tg, 0, rdy, vld, h);
      if (rdy) nacc++;
    end
    n_checks++;
    if (nacc !== 4) $display("[TB] FAIL rstmid_accepted: got %0d want 4", nacc);
    else n_pass++;
    @(negedge clk);
    bus.cmd_valid = 0; rst_n = 0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0)
      $display("[TB] FAIL rstmid_immediate: got vld=%b rdy=%b want 0 0", bus.rsp_valid, bus.cmd_ready);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      step(0, 2'b00, 32'h0, 32'h0, 4'd0, 1, rdy, vld, h);
      if (vld) nvld++;
    end
    n_checks++;
    if (nvld !== 0) $display("[TB] FAIL rstmid_no_rsp: got %0d rsps want 0", nvld);
    else n_pass++;
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    logic rdy, vld; rsp_t h;
    logic [1:0]  ops [5] = '{2'b00, 2'b11, 2'b01, 2'b11, 2'b10};
    logic [31:0] bs  [5] = '{32'd4, 32'd0, 32'd2, 32'd0, 32'd3};
    for (int i = 0; i < 5; i++) step(1, ops[i], 32'd9, bs[i], 4'(i), 1, rdy, vld, h);
    repeat (8) step(0, 2'b00, 32'h0, 32'h0, 4'd0, 1, rdy, vld, h);
    n_checks++;
    if (stat_ops !== 32'd5) $display("[TB] FAIL stat_ops: got %0d want 5", stat_ops);
    else n_pass++;
    n_checks++;
    if (stat_errs !== 16'd2) $display("[TB] FAIL stat_errs: got %0d want 2", stat_errs);
    else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_div_mul();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
